md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler for the 5-stage MIPS core. It sits beside the decode stage. It accepts MULT/MULTU/DIV/DIVU issues from decode and sequences a shared fixed-latency multiplier and a handshaked iterative divider. It owns the architectural HI/LO registers and stalls decode while a HI/LO consumer or a new mult/div would collide with an in-flight operation.

## Interface
Parameters:
- MUL_LAT, default 4: number of edges from the accept edge to the product-capture edge. Legal range 4..15.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- de_md_req  in  1  decode holds a MULT/MULTU/DIV/DIVU. Raw decode, not masked by stall.
- de_hilo_read  in  1  decode holds an MFHI/MFLO
- de_mult_en  in  1  mult issue (already masked by stall)
- de_div_en  in  1  div issue (already masked by stall)
- de_is_signed  in  1  signed operation
- de_MD_src1, de_MD_src2  in  32  forwarded rs and rt
- wb_hilo_we  in  2  [1] MTHI write, [0] MTLO write, from WB
- wb_hilo_wdata  in  32  MTHI/MTLO data
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_signed  out  1  signed operation
- mul_a, mul_b  out  32  latched operands
- mul_result  in  64  product {hi,lo}. Valid at the capture edge.
- div_start  out  1  one-cycle start pulse to the divider
- div_signed  out  1  signed operation
- div_a, div_b  out  32  latched operands
- div_done  in  1  one-cycle done pulse
- div_quot, div_rem  in  32  divider results, valid with div_done
- md_busy  out  1  state != IDLE
- md_stall  out  1  stall request to decode
- hi_out, lo_out  out  32  HI/LO registers, read by decode for MFHI/MFLO

## Operation
States: IDLE, MUL, DIV.

IDLE:
- If de_mult_en: latch operands into mul_a/mul_b and is_signed into mul_signed; clear cnt; go to MUL.
- Else if de_div_en and de_MD_src2 != 0: latch operands into div_a/div_b and is_signed into div_signed; go to DIV.
- Else if de_div_en and de_MD_src2 == 0: stay in IDLE; HI/LO unchanged; no div_start.
- If de_mult_en and de_div_en are both high, mult wins. Decode never produces this.

MUL:
- mul_start is high in the first MUL cycle only. It is a registered output.
- cnt is 4 bits and increments every cycle.
- On the edge where the total edge count since accept equals MUL_LAT:
  - {HI,LO} <= mul_result
  - go to IDLE
- There is no early exit.

DIV:
- div_start is high in the first DIV cycle only. It is a registered output.
- Wait for div_done. On that edge: HI <= div_rem, LO <= div_quot; go to IDLE.
- div_done in IDLE or MUL is ignored.
- The divider must not raise div_done earlier than 3 cycles after div_start.

Operands and signed flags are held stable from the accept edge until the return to IDLE.

HI/LO writes:
- wb_hilo_we bits write HI and/or LO from wb_hilo_wdata in any state.
- If a WB write and a completion capture happen on the same edge, the completion result wins for both HI and LO.

Stall:
- md_stall = md_busy & (de_md_req | de_hilo_read).
- It is combinational from registered state and decode inputs only, so there is no loop through the decode enables.

## Timing
- Reset values: state IDLE, cnt 0. HI, LO, mul_a, mul_b, div_a and div_b are 0. mul_start, div_start, mul_signed, div_signed, md_busy and md_stall are 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately. The divider shares reset; a stale div_done after reset is ignored because state is IDLE.
- Mult timing:
  - Accept at edge A.
  - md_busy is high during cycles A+1 through A+MUL_LAT.
  - HI/LO are updated at edge A+MUL_LAT.
  - md_busy is low and hi_out shows the new value in the following cycle.
- MUL_LAT ≥ 4 guarantees that any older MTHI/MTLO still in EXE/MEM/WB at accept has written before capture.
- Div latency = divider latency + 1 edge (accept) + capture edge.
- Back-to-back ops: a second mult/div in decode stalls while busy. It is accepted at the first edge where state is IDLE and stall has dropped, so there is no idle gap beyond the stall-release cycle.
- MFHI/MFLO issued in the cycle after a capture reads the new value with no stall.

## Test plan
- Signed mult, 0xFFFFFFFE × 3, MUL_LAT=4, multiplier model: exactly one mul_start pulse; md_busy high for 4 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA at edge A+4.
- MFLO held in decode right after a MULTU of 0x10000 × 0x10000: md_stall high for 4 cycles, then low; lo_out=0 and hi_out=1 in the release cycle.
- DIVU 100/7 with a divider model that raises div_done 10 cycles after div_start: LO=14, HI=2; md_busy drops the cycle after div_done.
- Signed DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV x/0: no div_start, md_busy stays 0, HI/LO unchanged.
- WB write collisions:
  - wb_hilo_we=2'b11 with data 0x55 on the mult capture edge: HI/LO take the product.
  - The same write while IDLE: HI=LO=0x55.
  - wb_hilo_we=2'b01 mid-MUL: LO=0x55 until capture.
- reset pulsed 3 cycles into a DIV: all outputs 0 immediately. A later div_done pulse leaves HI/LO at 0 and state IDLE.

Source files
------------

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched -- multiply/divide scheduler for the 5-stage MIPS core.
//
// Sits beside decode. Accepts MULT/MULTU/DIV/DIVU issues, drives a shared
// fixed-latency multiplier (MUL_LAT edges from accept to product capture) and
// a handshaked iterative divider, owns the architectural HI/LO registers and
// requests a decode stall while a HI/LO consumer or a new mult/div would
// collide with an in-flight operation.
//
// Ports:
//   clk, reset            core clock, asynchronous active-high reset
//   de_md_req             decode holds a mult/div (raw, not stall-masked)
//   de_hilo_read          decode holds an MFHI/MFLO
//   de_mult_en/de_div_en  stall-masked issue strobes
//   de_is_signed          signed operation
//   de_MD_src1/2          forwarded rs / rt operands
//   wb_hilo_we/wdata      MTHI ([1]) / MTLO ([0]) write from WB
//   mul_*                 multiplier start/operands, product {hi,lo} input
//   div_*                 divider start/operands, done pulse and results
//   md_busy               an operation is in flight
//   md_stall              stall request to decode
//   hi_out, lo_out        HI/LO registers
// -----------------------------------------------------------------------------
module md_sched #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_md_req,
  input  logic        de_hilo_read,
  input  logic        de_mult_en,
  input  logic        de_div_en,
  input  logic        de_is_signed,
  input  logic [31:0] de_MD_src1,
  input  logic [31:0] de_MD_src2,
  input  logic [1:0]  wb_hilo_we,
  input  logic [31:0] wb_hilo_wdata,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // cnt holds (edges since accept - 1) while in MUL, so the capture edge is
  // the one where cnt reaches MUL_LAT-1.
  localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       mul_accept, div_accept;
  logic       mul_capture, div_capture;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    mul_accept  = 1'b0;
    div_accept  = 1'b0;
    mul_capture = 1'b0;
    div_capture = 1'b0;
    case (state)
      IDLE: begin
        if (de_mult_en) begin
          mul_accept = 1'b1;
          state_nxt  = MUL;
        end else if (de_div_en && (de_MD_src2 != 32'd0)) begin
          // A divide by zero is dropped here: no start, HI/LO untouched.
          div_accept = 1'b1;
          state_nxt  = DIV;
        end
      end
      MUL: begin
        if (cnt == LAST_CNT) begin
          mul_capture = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DIV: begin
        if (div_done) begin
          div_capture = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Start pulses are registered: high only in the first cycle of MUL / DIV.
  // Operands and signed flags load on accept and hold until back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 4'd0;
      mul_start  <= 1'b0;
      mul_signed <= 1'b0;
      mul_a      <= 32'd0;
      mul_b      <= 32'd0;
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      div_a      <= 32'd0;
      div_b      <= 32'd0;
    end else begin
      mul_start <= mul_accept;
      div_start <= div_accept;
      if (mul_accept) begin
        cnt        <= 4'd0;
        mul_signed <= de_is_signed;
        mul_a      <= de_MD_src1;
        mul_b      <= de_MD_src2;
      end else if (state == MUL) begin
        cnt <= cnt + 4'd1;
      end
      if (div_accept) begin
        div_signed <= de_is_signed;
        div_a      <= de_MD_src1;
        div_b      <= de_MD_src2;
      end
    end
  end

  // A completion capture overrides a same-edge MTHI/MTLO for both halves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (mul_capture) begin
      hi_out <= mul_result[63:32];
      lo_out <= mul_result[31:0];
    end else if (div_capture) begin
      hi_out <= div_rem;
      lo_out <= div_quot;
    end else begin
      if (wb_hilo_we[1]) hi_out <= wb_hilo_wdata;
      if (wb_hilo_we[0]) lo_out <= wb_hilo_wdata;
    end
  end

  // Stall depends only on registered state and raw decode inputs, never on
  // the stall-masked enables, so there is no combinational loop.
  assign md_busy  = (state != IDLE);
  assign md_stall = md_busy & (de_md_req | de_hilo_read);

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched -- self-checking bench for md_sched with behavioural multiplier
// and divider models. Table-driven mult/div vectors plus hand-written
// sequences for the stall, HI/LO write-collision and reset corner cases.
// -----------------------------------------------------------------------------
module tb_md_sched;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_md_req, de_hilo_read, de_mult_en, de_div_en, de_is_signed;
  logic [31:0] de_MD_src1, de_MD_src2;
  logic [1:0]  wb_hilo_we;
  logic [31:0] wb_hilo_wdata;
  logic        mul_start, mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_done;
  logic [31:0] div_quot, div_rem;
  logic        md_busy, md_stall;
  logic [31:0] hi_out, lo_out;

  logic        div_done_inj;
  int          m_cnt;
  int          d_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .de_md_req(de_md_req), .de_hilo_read(de_hilo_read),
    .de_mult_en(de_mult_en), .de_div_en(de_div_en),
    .de_is_signed(de_is_signed),
    .de_MD_src1(de_MD_src1), .de_MD_src2(de_MD_src2),
    .wb_hilo_we(wb_hilo_we), .wb_hilo_wdata(wb_hilo_wdata),
    .mul_start(mul_start), .mul_signed(mul_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem),
    .md_busy(md_busy), .md_stall(md_stall),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  // Multiplier model: the product is only presented in the cycle of the
  // capture edge (MUL_LAT-1 cycles after the mul_start cycle); otherwise a
  // garbage pattern, so an early or late capture is visible in HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         m_cnt <= 0;
    else if (mul_start)                m_cnt <= 1;
    else if (m_cnt != 0 && m_cnt < 15) m_cnt <= m_cnt + 1;
  end

  always_comb begin
    logic [63:0] ea, eb;
    ea = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
    eb = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
    mul_result = (m_cnt == MUL_LAT - 1) ? (ea * eb) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  // Divider model: div_done pulses DIV_LAT cycles after the div_start cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                d_cnt <= 0;
    else if (div_start)                       d_cnt <= 1;
    else if (d_cnt != 0 && d_cnt < DIV_LAT)   d_cnt <= d_cnt + 1;
    else                                      d_cnt <= 0;
  end

  assign div_done = (d_cnt == DIV_LAT) | div_done_inj;

  always_comb begin
    div_quot = 32'd0;
    div_rem  = 32'd0;
    if (div_b != 32'd0) begin
      if (div_signed) begin
        div_quot = $signed(div_a) / $signed(div_b);
        div_rem  = $signed(div_a) % $signed(div_b);
      end else begin
        div_quot = div_a / div_b;
        div_rem  = div_a % div_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef enum logic {OP_MULT, OP_DIV} op_e;

  typedef struct {
    op_e         op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
    int          exp_starts;
  } vec_t;

  vec_t vecs[7];

  // Issue one op at the current (IDLE) cycle; the next edge is the accept
  // edge. Returns the number of busy cycles and start pulses seen.
  task automatic run_op(input op_e op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int busy, output int starts);
    de_md_req    = 1'b1;
    de_is_signed = sgn;
    de_MD_src1   = a;
    de_MD_src2   = b;
    de_mult_en   = (op == OP_MULT);
    de_div_en    = (op == OP_DIV);
    tick();
    de_md_req    = 1'b0;
    de_mult_en   = 1'b0;
    de_div_en    = 1'b0;
    de_is_signed = ~sgn;
    de_MD_src1   = 32'hA5A5_A5A5;
    de_MD_src2   = 32'h5A5A_5A5A;
    busy   = 0;
    starts = 0;
    while (md_busy && busy < 100) begin
      busy++;
      if (mul_start || div_start) starts++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int busy, starts, stall_cycles;

    vecs[0] = '{OP_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 4,  1};
    vecs[1] = '{OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4,  1};
    vecs[2] = '{OP_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 4,  1};
    vecs[3] = '{OP_DIV,  1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        11, 1};
    vecs[4] = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 11, 1};
    vecs[5] = '{OP_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC, 11, 1};
    vecs[6] = '{OP_DIV,  1'b0, 32'd5,         32'd0,         32'd1,         32'h7FFF_FFFC, 0,  0};

    reset         = 1'b1;
    de_md_req     = 1'b0;
    de_hilo_read  = 1'b0;
    de_mult_en    = 1'b0;
    de_div_en     = 1'b0;
    de_is_signed  = 1'b0;
    de_MD_src1    = 32'd0;
    de_MD_src2    = 32'd0;
    wb_hilo_we    = 2'b00;
    wb_hilo_wdata = 32'd0;
    div_done_inj  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("reset hi", hi_out, 0);
    check("reset lo", lo_out, 0);
    check("reset busy", md_busy, 0);
    check("reset mul_start", mul_start, 0);
    check("reset div_start", div_start, 0);
    check("reset mul_a", mul_a, 0);
    check("reset div_b", div_b, 0);

    // Table-driven mult/div vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, busy, starts);
      check($sformatf("vec%0d busy cycles", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d start pulses", i), starts, vecs[i].exp_starts);
      check($sformatf("vec%0d hi", i), hi_out, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), lo_out, vecs[i].exp_lo);
    end

    // WB writes while IDLE
    wb_hilo_we = 2'b11; wb_hilo_wdata = 32'h55;
    tick();
    wb_hilo_we = 2'b10; wb_hilo_wdata = 32'h12;
    check("idle wb both hi", hi_out, 32'h55);
    check("idle wb both lo", lo_out, 32'h55);
    tick();
    wb_hilo_we = 2'b00;
    check("idle wb hi only hi", hi_out, 32'h12);
    check("idle wb hi only lo", lo_out, 32'h55);

    de_md_req = 1'b1;
    #1;
    check("idle no stall", md_stall, 0);

    // MULTU 3*5 with an MTLO mid-MUL and an MTHI+MTLO on the capture edge
    de_mult_en = 1'b1; de_is_signed = 1'b0; de_MD_src1 = 32'd3; de_MD_src2 = 32'd5;
    tick();                                   // accept edge A
    de_md_req = 1'b0; de_mult_en = 1'b0;
    de_MD_src1 = 32'hA5A5_A5A5; de_MD_src2 = 32'h5A5A_5A5A;
    wb_hilo_we = 2'b01; wb_hilo_wdata = 32'h99;
    tick();                                   // cycle A+2
    wb_hilo_we = 2'b00;
    check("mid-mul wb lo", lo_out, 32'h99);
    check("mid-mul wb hi kept", hi_out, 32'h12);
    de_md_req = 1'b1;
    #1;
    check("mid-mul md_req stall", md_stall, 1);
    de_md_req = 1'b0;
    tick();                                   // cycle A+3
    tick();                                   // cycle A+4
    check("busy in last mul cycle", md_busy, 1);
    wb_hilo_we = 2'b11; wb_hilo_wdata = 32'h55;
    tick();                                   // cycle A+5
    wb_hilo_we = 2'b00;
    check("capture beats wb hi", hi_out, 32'h0);
    check("capture beats wb lo", lo_out, 32'hF);
    check("idle after capture", md_busy, 0);

    // MFLO held in decode behind MULTU 0x10000 * 0x10000
    de_md_req = 1'b1; de_mult_en = 1'b1; de_is_signed = 1'b0;
    de_MD_src1 = 32'h1_0000; de_MD_src2 = 32'h1_0000;
    tick();
    de_md_req = 1'b0; de_mult_en = 1'b0; de_hilo_read = 1'b1;
    stall_cycles = 0;
    while (md_stall && stall_cycles < 100) begin
      stall_cycles++;
      tick();
    end
    check("mflo stall cycles", stall_cycles, 4);
    check("mflo release stall", md_stall, 0);
    check("mflo release lo", lo_out, 32'h0);
    check("mflo release hi", hi_out, 32'h1);
    de_hilo_read = 1'b0;

    // Reset pulsed three cycles into a DIVU 100/7
    de_md_req = 1'b1; de_div_en = 1'b1; de_MD_src1 = 32'd100; de_MD_src2 = 32'd7;
    tick();
    de_div_en = 1'b0;
    tick();
    tick();
    check("div in flight", md_busy, 1);
    reset = 1'b1;
    #1;
    check("async reset busy", md_busy, 0);
    check("async reset stall", md_stall, 0);
    check("async reset hi", hi_out, 0);
    check("async reset lo", lo_out, 0);
    check("async reset div_a", div_a, 0);
    check("async reset div_start", div_start, 0);
    de_md_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    div_done_inj = 1'b1;
    tick();
    div_done_inj = 1'b0;
    for (int i = 0; i < DIV_LAT + 2; i++) tick();
    check("stale done busy", md_busy, 0);
    check("stale done hi", hi_out, 0);
    check("stale done lo", lo_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
